mci_wdt_multi: RTL

// - N-channel watchdog for MCI; successor to the fixed two-timer WDT. Sits beside the MCI CSR bank, driven by
//   per-timer enable/restart/period/serviced fields; returns timeout pulses, sticky status and a fatal flag.
// - Adds a run-time selectable cascade mode (timer i arms only after timer i-1 expires), period width set by

---
 rtl/mci_pkg.sv | 18 +
 rtl/mci_wdt_timer.sv | 113 +++++++++++
 rtl/mci_wdt_multi.sv | 103 ++++++++++
 3 files changed

// File: rtl/mci_pkg.sv
// -----------------------------------------------------------------------------
// mci_pkg
// Shared types and constants for the MCI watchdog block.
//   WDT_TIMEOUT_PERIOD_NUM_DWORDS : default period/counter width in 32-bit dwords
//   mci_wdt_state_e               : per-channel watchdog state
// -----------------------------------------------------------------------------
package mci_pkg;

    localparam int WDT_TIMEOUT_PERIOD_NUM_DWORDS = 2;

    // Encodings 0/1/2 are all one-hot-or-zero, so a stray 2'b11 is detectable.
    typedef enum logic [1:0] {
        WDT_IDLE,
        WDT_COUNT,
        WDT_EXPIRED
    } mci_wdt_state_e;

endpackage

// File: rtl/mci_wdt_timer.sv
// -----------------------------------------------------------------------------
// mci_wdt_timer
// One watchdog channel: state machine, W-bit up-counter, one-cycle timeout
// pulse and sticky timeout status.
//   clk, rst_b    : clock, synchronous active-low reset
//   arm           : channel may count (enable already combined with chaining)
//   restart       : clear the counter while counting
//   serviced      : clear sticky status; leaves EXPIRED when still armed
//   period        : live expiry threshold (count >= period expires)
//   state_nxt     : next state, used by the top level to arm the next channel
//   timeout_p     : one-cycle pulse on entry to EXPIRED
//   timeout_sts   : sticky status, set on expiry
//   count         : live counter value
// -----------------------------------------------------------------------------
module mci_wdt_timer
    import mci_pkg::*;
#(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           arm,
    input  logic           restart,
    input  logic           serviced,
    input  logic [W-1:0]   period,
    output mci_wdt_state_e state_nxt,
    output logic           timeout_p,
    output logic           timeout_sts,
    output logic [W-1:0]   count
);

    mci_wdt_state_e state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           pulse_q, pulse_d;
    logic           sts_q,   sts_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = 1'b0;
        sts_d   = sts_q;

        // Service clears status in every state; an expiry below overrides it.
        if (serviced) begin
            sts_d = 1'b0;
        end

        case (state_q)
            WDT_IDLE: begin
                count_d = '0;
                if (arm) begin
                    state_d = WDT_COUNT;
                end
            end
            WDT_COUNT: begin
                if (!arm) begin
                    state_d = WDT_IDLE;
                    count_d = '0;
                end else if (restart) begin
                    count_d = '0;
                end else if (count_q >= period) begin
                    // The >= compare also bounds the counter: with period at
                    // its maximum the channel expires at count == 2^W-1.
                    state_d = WDT_EXPIRED;
                    pulse_d = 1'b1;
                    sts_d   = 1'b1;
                end else begin
                    count_d = count_q + W'(1);
                end
            end
            WDT_EXPIRED: begin
                // Count holds for readback; restart has no effect here.
                if (!arm) begin
                    state_d = WDT_IDLE;
                    count_d = '0;
                end else if (serviced) begin
                    state_d = WDT_COUNT;
                    count_d = '0;
                end
            end
            default: begin
                state_d = WDT_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= WDT_IDLE;
            count_q <= '0;
            pulse_q <= 1'b0;
            sts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
            sts_q   <= sts_d;
        end
    end

    assign state_nxt   = state_d;
    assign timeout_p   = pulse_q;
    assign timeout_sts = sts_q;
    assign count       = count_q;

    a_state_legal: assert property (@(posedge clk) disable iff (!rst_b)
        $onehot0(state_q));

    a_pulse_single: assert property (@(posedge clk) disable iff (!rst_b)
        timeout_p |=> !timeout_p);

endmodule

// File: rtl/mci_wdt_multi.sv
// -----------------------------------------------------------------------------
// mci_wdt_multi
// N-channel watchdog for the MCI CSR bank with optional cascade chaining.
//   clk, rst_b           : clock, synchronous active-low reset
//   cascade_mode         : 1 = channel i arms only once channel i-1 expired
//   timer_en             : per-channel enable level
//   timer_restart        : per-channel restart pulse
//   timer_timeout_period : per-channel period, dword 0 is least significant
//   timeout_serviced     : per-channel status clear / re-arm pulse
//   timeout_p            : per-channel one-cycle timeout pulse
//   timeout_sts          : per-channel sticky timeout status
//   timer_count          : per-channel live counter
//   fatal_o              : last channel expired while cascaded (sticky)
// -----------------------------------------------------------------------------
module mci_wdt_multi
    import mci_pkg::*;
#(
    parameter int NUM_TIMERS    = 2,
    parameter int PERIOD_DWORDS = WDT_TIMEOUT_PERIOD_NUM_DWORDS
) (
    input  logic                                            clk,
    input  logic                                            rst_b,
    input  logic                                            cascade_mode,
    input  logic [NUM_TIMERS-1:0]                           timer_en,
    input  logic [NUM_TIMERS-1:0]                           timer_restart,
    input  logic [NUM_TIMERS-1:0][PERIOD_DWORDS-1:0][31:0]  timer_timeout_period,
    input  logic [NUM_TIMERS-1:0]                           timeout_serviced,
    output logic [NUM_TIMERS-1:0]                           timeout_p,
    output logic [NUM_TIMERS-1:0]                           timeout_sts,
    output logic [NUM_TIMERS-1:0][32*PERIOD_DWORDS-1:0]     timer_count,
    output logic                                            fatal_o
);

    localparam int W = 32 * PERIOD_DWORDS;

    logic mode_q, mode_d;
    logic fatal_q, fatal_d;
    logic last_exp_q, last_exp_d;
    logic mode_chg;

    // Any change of cascade_mode seen against the registered copy holds the
    // downstream channels idle for one cycle so they restart cleanly.
    assign mode_chg = cascade_mode ^ mode_q;

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
        logic           arm;
        mci_wdt_state_e state_nxt;

        if (gi == 0) begin : g_head
            assign arm = timer_en[0];
        end else begin : g_link
            // Chaining looks at the previous channel's next state, so channel
            // i starts counting on the same edge channel i-1 expires, and
            // drops on the same edge channel i-1 is serviced.
            assign arm = timer_en[gi] && !mode_chg &&
                         (!cascade_mode || (g_ch[gi-1].state_nxt == WDT_EXPIRED));
        end

        mci_wdt_timer #(
            .W (W)
        ) u_timer (
            .clk         (clk),
            .rst_b       (rst_b),
            .arm         (arm),
            .restart     (timer_restart[gi]),
            .serviced    (timeout_serviced[gi]),
            .period      (timer_timeout_period[gi]),
            .state_nxt   (state_nxt),
            .timeout_p   (timeout_p[gi]),
            .timeout_sts (timeout_sts[gi]),
            .count       (timer_count[gi])
        );
    end

    always_comb begin
        mode_d     = cascade_mode;
        last_exp_d = (g_ch[NUM_TIMERS-1].state_nxt == WDT_EXPIRED);
        fatal_d    = fatal_q;
        // Entry into EXPIRED of the last channel: expired next, not expired now.
        if (cascade_mode && last_exp_d && !last_exp_q) begin
            fatal_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // The mode copy tracks through reset so leaving reset with cascade
        // already selected is not seen as a change.
        mode_q <= mode_d;
        if (!rst_b) begin
            fatal_q    <= 1'b0;
            last_exp_q <= 1'b0;
        end else begin
            fatal_q    <= fatal_d;
            last_exp_q <= last_exp_d;
        end
    end

    assign fatal_o = fatal_q;

    a_fatal_cascade: assert property (@(posedge clk) disable iff (!rst_b)
        $rose(fatal_o) |-> $past(cascade_mode));

endmodule
